// File: rtl/cx_multadd_pipe.sv
// rtl/cx_multadd_pipe.sv - streaming complex multiply-add (A*B or A*conj(B), +/- C) with round/saturate
module cx_multadd_pipe #(
    parameter int AW = 16,
    parameter int AF = 15,
    parameter int BW = 16,
    parameter int BF = 15,
    parameter int CW = 16,
    parameter int CF = 15,
    parameter int OW = 16,
    parameter int OF = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic signed [AW-1:0] a_re,
    input  logic signed [AW-1:0] a_im,
    input  logic signed [BW-1:0] b_re,
    input  logic signed [BW-1:0] b_im,
    input  logic signed [CW-1:0] c_re,
    input  logic signed [CW-1:0] c_im,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic                 ovf,
    output logic                 ovf_sticky,
    input  logic                 ovf_clr
);

    localparam int IW  = AW + BW + 4;
    localparam int PW  = AW + BW + 2;
    localparam int CSH = AF + BF - CF;
    localparam int RSH = AF + BF - OF;

    localparam logic signed [IW-1:0] RND     = IW'(1) <<< (RSH - 1);
    localparam logic signed [IW-1:0] SAT_MAX = (IW'(1) <<< (OW - 1)) - IW'(1);
    localparam logic signed [IW-1:0] SAT_MIN = -(IW'(1) <<< (OW - 1));
    localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

    // vld[k]/sub[k] qualify the sample held in stage k; sub is mode[0] travelling with it
    logic [5:1] vld;
    logic [4:1] sub;

    logic signed [AW-1:0] a_re1, a_im1, a_re2, a_im2;
    logic signed [BW-1:0] b_re1;
    logic signed [BW:0]   b_im1, b_im2;
    logic signed [CW-1:0] c_re_d [1:4];
    logic signed [CW-1:0] c_im_d [1:4];
    logic signed [AW:0]   d2;
    logic signed [BW+1:0] pr2, pi2;
    logic signed [PW-1:0] mc3, mr3, mi3;
    logic signed [IW-1:0] x_re4, x_im4, y_re5, y_im5;
    logic signed [IW-1:0] c_re_ext, c_im_ext;
    logic signed [IW-1:0] rnd_re, rnd_im;
    logic signed [OW-1:0] sat_re, sat_im;
    logic                 ovf_re, ovf_im;

    assign c_re_ext = IW'(c_re_d[4]) <<< CSH;
    assign c_im_ext = IW'(c_im_d[4]) <<< CSH;

    // Three-multiplier form: re = a_re*(b_re-b_im) + (a_re-a_im)*b_im, im = a_im*(b_re+b_im) + same term
    always_ff @(posedge clk) begin
        if (en) begin
            a_re1     <= a_re;
            a_im1     <= a_im;
            b_re1     <= b_re;
            b_im1     <= mode[1] ? -(BW+1)'(b_im) : (BW+1)'(b_im);
            c_re_d[1] <= c_re;
            c_im_d[1] <= c_im;

            d2        <= (AW+1)'(a_re1) - (AW+1)'(a_im1);
            pr2       <= (BW+2)'(b_re1) - (BW+2)'(b_im1);
            pi2       <= (BW+2)'(b_re1) + (BW+2)'(b_im1);
            a_re2     <= a_re1;
            a_im2     <= a_im1;
            b_im2     <= b_im1;
            c_re_d[2] <= c_re_d[1];
            c_im_d[2] <= c_im_d[1];

            mc3       <= PW'(d2) * PW'(b_im2);
            mr3       <= PW'(a_re2) * PW'(pr2);
            mi3       <= PW'(a_im2) * PW'(pi2);
            c_re_d[3] <= c_re_d[2];
            c_im_d[3] <= c_im_d[2];

            x_re4     <= IW'(mr3) + IW'(mc3);
            x_im4     <= IW'(mi3) + IW'(mc3);
            c_re_d[4] <= c_re_d[3];
            c_im_d[4] <= c_im_d[3];

            y_re5     <= sub[4] ? x_re4 - c_re_ext : x_re4 + c_re_ext;
            y_im5     <= sub[4] ? x_im4 - c_im_ext : x_im4 + c_im_ext;
        end
    end

    always_comb begin
        rnd_re = (y_re5 + RND) >>> RSH;
        rnd_im = (y_im5 + RND) >>> RSH;
        sat_re = rnd_re[OW-1:0];
        sat_im = rnd_im[OW-1:0];
        ovf_re = 1'b0;
        ovf_im = 1'b0;
        if (rnd_re > SAT_MAX) begin
            sat_re = OUT_MAX;
            ovf_re = 1'b1;
        end else if (rnd_re < SAT_MIN) begin
            sat_re = OUT_MIN;
            ovf_re = 1'b1;
        end
        if (rnd_im > SAT_MAX) begin
            sat_im = OUT_MAX;
            ovf_im = 1'b1;
        end else if (rnd_im < SAT_MIN) begin
            sat_im = OUT_MIN;
            ovf_im = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            sub       <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            vld       <= {vld[4:1], in_valid};
            sub       <= {sub[3:1], mode[0]};
            out_valid <= vld[5];
            out_re    <= sat_re;
            out_im    <= sat_im;
            ovf       <= vld[5] & (ovf_re | ovf_im);
        end
    end

    // A saturating sample landing on the same edge as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= (en & vld[5] & (ovf_re | ovf_im)) | (ovf_sticky & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_cx_multadd_pipe.sv
// tb/tb_cx_multadd_pipe.sv - scoreboard bench for cx_multadd_pipe
module tb_cx_multadd_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, en, in_valid, ovf_clr;
    logic [1:0]        mode;
    logic signed [15:0] a_re, a_im, b_re, b_im, c_re, c_im;
    logic              out_valid, ovf, ovf_sticky;
    logic signed [15:0] out_re, out_im;

    cx_multadd_pipe dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .mode(mode),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .c_re(c_re), .c_im(c_im),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               ov;
        int                 edge_n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                   input int cr, input int ci, input logic [1:0] md);
        longint bq, xr, xi, yr, yi, rr, ri;
        exp_t   e;
        bq = md[1] ? -bi : bi;
        xr = longint'(ar) * br - longint'(ai) * bq;
        xi = longint'(ar) * bq + longint'(ai) * br;
        yr = md[0] ? xr - (longint'(cr) <<< 15) : xr + (longint'(cr) <<< 15);
        yi = md[0] ? xi - (longint'(ci) <<< 15) : xi + (longint'(ci) <<< 15);
        rr = (yr + 16384) >>> 15;
        ri = (yi + 16384) >>> 15;
        e.ov = 1'b0;
        if (rr > 32767) begin rr = 32767; e.ov = 1'b1; end
        else if (rr < -32768) begin rr = -32768; e.ov = 1'b1; end
        if (ri > 32767) begin ri = 32767; e.ov = 1'b1; end
        else if (ri < -32768) begin ri = -32768; e.ov = 1'b1; end
        e.re = rr[15:0];
        e.im = ri[15:0];
        e.edge_n = 0;
        return e;
    endfunction

    task automatic cyc(input logic e_v, input logic v, input int ar, input int ai, input int br,
                       input int bi, input int cr, input int ci, input logic [1:0] md,
                       input logic push, input exp_t ex);
        exp_t x;
        @(negedge clk);
        en = e_v; in_valid = v; mode = md;
        a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
        c_re = 16'(cr); c_im = 16'(ci);
        if (push) begin
            x = ex;
            x.edge_n = en_cnt + 6;
            sb.push_back(x);
        end
    endtask

    task automatic idle();
        exp_t z;
        z = '{re: 0, im: 0, ov: 0, edge_n: 0};
        cyc(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0, z);
    endtask

    task automatic send_h(input int ar, input int ai, input int br, input int bi, input int cr,
                          input int ci, input logic [1:0] md, input int re, input int im, input logic ov);
        exp_t e;
        e = '{re: 16'(re), im: 16'(im), ov: ov, edge_n: 0};
        cyc(1'b1, 1'b1, ar, ai, br, bi, cr, ci, md, 1'b1, e);
    endtask

    task automatic send_m(input int ar, input int ai, input int br, input int bi, input int cr,
                          input int ci, input logic [1:0] md, input logic push);
        cyc(1'b1, 1'b1, ar, ai, br, bi, cr, ci, md, push, model(ar, ai, br, bi, cr, ci, md));
    endtask

    task automatic frozen();
        exp_t z;
        z = '{re: 0, im: 0, ov: 0, edge_n: 0};
        cyc(1'b0, 1'b1, 31111, -22222, 12121, -3, 999, -999, 2'b11, 1'b0, z);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            idle();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (2) idle();
    endtask

    // Monitor: pops on every enabled edge that presents out_valid; checks hold on disabled edges
    initial begin
        logic              e_edge;
        logic              p_v, p_o;
        logic signed [15:0] p_re, p_im;
        exp_t              ex;
        p_v = 1'b0; p_o = 1'b0; p_re = '0; p_im = '0;
        forever begin
            @(posedge clk);
            e_edge = en && rst_n;
            if (e_edge) en_cnt++;
            #1;
            if (rst_n) begin
                if (!e_edge) begin
                    chk("freeze_valid", out_valid, p_v);
                    chk("freeze_re", out_re, p_re);
                    chk("freeze_im", out_im, p_im);
                    chk("freeze_ovf", ovf, p_o);
                end else if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", out_valid, 0);
                    end else begin
                        ex = sb.pop_front();
                        chk("out_re", out_re, ex.re);
                        chk("out_im", out_im, ex.im);
                        chk("ovf", ovf, ex.ov);
                        chk("latency_edge", en_cnt, ex.edge_n);
                        if (ex.ov) chk("sticky_set", ovf_sticky, 1);
                    end
                end
            end
            p_v = out_valid; p_o = ovf; p_re = out_re; p_im = out_im;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int fa_r[8] = '{12345, -20000, 32767, -32768, 100, -7, 30000, -15000};
    int fa_i[8] = '{-321, 15000, 32767, -32768, -100, 8, -30000, 2};
    int fb_r[8] = '{32767, -16384, 32767, -32768, 5000, 1, 20000, -32768};
    int fb_i[8] = '{1000, 8191, -32768, -32768, -5000, -1, 12345, 32767};
    int fc_r[8] = '{0, 1000, -32768, 32767, 7, -3, -12000, 500};
    int fc_i[8] = '{5, -1000, 32767, -32768, -7, 3, 9000, -500};
    logic [1:0] fm[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; ovf_clr = 1'b0; mode = 2'b00;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; c_re = '0; c_im = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_re", out_re, 0);
        chk("reset_out_im", out_im, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_sticky", ovf_sticky, 0);
        rst_n = 1'b1;

        send_h(16384, 16384, 16384, -16384, 0, 0, 2'b00, 16384, 0, 0);
        drain();
        chk("sticky_clean", ovf_sticky, 0);

        send_h(16384, 16384, 16384, -16384, 0, 0, 2'b10, 0, 16384, 0);
        send_h(16384, 0, 0, -32768, 0, 0, 2'b10, 0, 16384, 0);
        drain();

        send_h(-32768, 0, -32768, 0, 16384, 0, 2'b00, 32767, 0, 1);
        send_h(-32768, 0, -32768, 0, 16384, 0, 2'b01, 16384, 0, 0);
        drain();
        chk("sticky_hold", ovf_sticky, 1);
        frozen();
        ovf_clr = 1'b1;
        idle();
        ovf_clr = 1'b0;
        chk("sticky_clr_while_disabled", ovf_sticky, 0);

        send_h(1, 0, 16384, 0, 0, 0, 2'b00, 1, 0, 0);
        send_h(-1, 0, 16384, 0, 0, 0, 2'b00, 0, 0, 0);
        send_h(-32768, 0, 32767, 0, -16384, 0, 2'b00, -32768, 0, 1);
        send_h(-32768, -32768, -32768, -32768, 0, 0, 2'b00, 0, 32767, 1);
        drain();

        ovf_clr = 1'b1;
        idle();
        chk("sticky_cleared", ovf_sticky, 0);
        send_h(-32768, 0, -32768, 0, 16384, 0, 2'b00, 32767, 0, 1);
        drain();
        chk("sticky_clr_after_set", ovf_sticky, 0);
        ovf_clr = 1'b0;

        send_m(fa_r[0], fa_i[0], fb_r[0], fb_i[0], fc_r[0], fc_i[0], fm[0], 1'b1);
        send_m(fa_r[1], fa_i[1], fb_r[1], fb_i[1], fc_r[1], fc_i[1], fm[1], 1'b1);
        idle();
        for (int i = 2; i < 6; i++)
            send_m(fa_r[i], fa_i[i], fb_r[i], fb_i[i], fc_r[i], fc_i[i], fm[i], 1'b1);
        repeat (3) frozen();
        idle();
        for (int i = 6; i < 8; i++)
            send_m(fa_r[i], fa_i[i], fb_r[i], fb_i[i], fc_r[i], fc_i[i], fm[i], 1'b1);
        drain();

        send_m(fa_r[0], fa_i[0], fb_r[0], fb_i[0], fc_r[0], fc_i[0], fm[0], 1'b1);
        for (int i = 1; i < 5; i++)
            send_m(fa_r[i], fa_i[i], fb_r[i], fb_i[i], fc_r[i], fc_i[i], fm[i], 1'b0);
        idle();
        @(posedge clk);
        #2;
        chk("pre_reset_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_re", out_re, 0);
        chk("async_reset_im", out_im, 0);
        chk("async_reset_sticky", ovf_sticky, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) idle();
        chk("reset_flush_queue", sb.size(), 0);
        send_m(fa_r[6], fa_i[6], fb_r[6], fb_i[6], fc_r[6], fc_i[6], fm[6], 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
